// File: rtl/triplet_capture_fifo.sv
// Atomic x/y/z triplet capture into a first-word-fall-through FIFO with sequence numbering and drop counting.
// Optional build macro TRIPLET_TS_EN adds a per-triplet 32-bit cycle timestamp on m_ts_o.
module triplet_capture_fifo #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic                       sample_i,
   input  logic [31:0]                x_i,
   input  logic [31:0]                y_i,
   input  logic [31:0]                z_i,
   output logic                       m_valid_o,
   input  logic                       m_ready_i,
   output logic [31:0]                m_x_o,
   output logic [31:0]                m_y_o,
   output logic [31:0]                m_z_o,
   output logic [CNT_W-1:0]           m_seq_o,
`ifdef TRIPLET_TS_EN
   output logic [31:0]                m_ts_o,
`endif
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic [CNT_W-1:0]           drop_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [31:0]      mem_x [DEPTH];
   logic [31:0]      mem_y [DEPTH];
   logic [31:0]      mem_z [DEPTH];
   logic [CNT_W-1:0] mem_seq [DEPTH];

   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [PW-1:0]    rd_nxt;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    remain;
   logic [CNT_W-1:0] seq_q;
   logic [CNT_W-1:0] drop_q;
   logic             ovf_q;

   logic full;
   logic pop;
   logic push;
   logic drop;
   logic load_in;
   logic load_mem;
   logic wr_en;

   assign full     = (level_q == LW'(DEPTH));
   assign pop      = m_valid_o & m_ready_i;
   assign push     = sample_i & (~full | pop);
   assign drop     = sample_i & full & ~pop;
   assign remain   = level_q - LW'(pop);
   assign rd_nxt   = rd_q + PW'(1);
   // Head register takes the incoming triplet only when it becomes the sole entry.
   assign load_in  = push & (remain == '0);
   assign load_mem = pop & (remain != '0);
   assign wr_en    = push & rst_n & ~clear_i;

   assign m_valid_o  = (level_q != '0);
   assign level_o    = level_q;
   assign overflow_o = ovf_q;
   assign drop_cnt_o = drop_q;

`ifdef TRIPLET_TS_EN
   logic [31:0] ts_cnt_q;
   logic [31:0] mem_ts [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_cnt_q <= '0;
         m_ts_o   <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (!clear_i) begin
            if (load_in)
               m_ts_o <= ts_cnt_q;
            else if (load_mem)
               m_ts_o <= mem_ts[rd_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_ts[wr_q] <= ts_cnt_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_x[wr_q]   <= x_i;
         mem_y[wr_q]   <= y_i;
         mem_z[wr_q]   <= z_i;
         mem_seq[wr_q] <= seq_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         seq_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
         m_x_o   <= '0;
         m_y_o   <= '0;
         m_z_o   <= '0;
         m_seq_o <= '0;
      end else if (clear_i) begin
         // Head data registers keep their last value; only the valid state is flushed.
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         seq_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push)
            wr_q <= wr_q + PW'(1);
         if (pop)
            rd_q <= rd_nxt;
         level_q <= level_q + LW'(push) - LW'(pop);
         seq_q   <= seq_q + CNT_W'(sample_i);
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != '1)
               drop_q <= drop_q + CNT_W'(1);
         end
         if (load_in) begin
            m_x_o   <= x_i;
            m_y_o   <= y_i;
            m_z_o   <= z_i;
            m_seq_o <= seq_q;
         end else if (load_mem) begin
            m_x_o   <= mem_x[rd_nxt];
            m_y_o   <= mem_y[rd_nxt];
            m_z_o   <= mem_z[rd_nxt];
            m_seq_o <= mem_seq[rd_nxt];
         end
      end
   end

endmodule

// File: tb/tb_triplet_capture_fifo.sv
// Scoreboard bench for triplet_capture_fifo: expected triplets queued at push, compared at the head.
// Timestamp checks are active when TRIPLET_TS_EN is defined.
module tb_triplet_capture_fifo;
   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0]      x;
      logic [31:0]      y;
      logic [31:0]      z;
      logic [CNT_W-1:0] seq;
      logic [31:0]      ts;
   } trip_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear_i = 1'b0;
   logic              sample_i = 1'b0;
   logic [31:0]       x_i = '0;
   logic [31:0]       y_i = '0;
   logic [31:0]       z_i = '0;
   logic              m_ready_i = 1'b0;
   logic              m_valid_o;
   logic [31:0]       m_x_o, m_y_o, m_z_o;
   logic [CNT_W-1:0]  m_seq_o;
`ifdef TRIPLET_TS_EN
   logic [31:0]       m_ts_o;
`endif
   logic [LW-1:0]     level_o;
   logic              overflow_o;
   logic [CNT_W-1:0]  drop_cnt_o;

   triplet_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear_i),
      .sample_i   (sample_i),
      .x_i        (x_i),
      .y_i        (y_i),
      .z_i        (z_i),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_x_o      (m_x_o),
      .m_y_o      (m_y_o),
      .m_z_o      (m_z_o),
      .m_seq_o    (m_seq_o),
`ifdef TRIPLET_TS_EN
      .m_ts_o     (m_ts_o),
`endif
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   trip_t            q[$];
   logic [CNT_W-1:0] seq_m;
   logic [CNT_W-1:0] drop_m;
   logic             ovf_m;
   logic [31:0]      ts_m;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".level"}, 64'(level_o), 64'(q.size()));
      chk({tag, ".valid"}, 64'(m_valid_o), 64'(q.size() != 0));
      chk({tag, ".drops"}, 64'(drop_cnt_o), 64'(drop_m));
      chk({tag, ".ovf"}, 64'(overflow_o), 64'(ovf_m));
      if (q.size() != 0) begin
         chk({tag, ".x"}, 64'(m_x_o), 64'(q[0].x));
         chk({tag, ".y"}, 64'(m_y_o), 64'(q[0].y));
         chk({tag, ".z"}, 64'(m_z_o), 64'(q[0].z));
         chk({tag, ".seq"}, 64'(m_seq_o), 64'(q[0].seq));
`ifdef TRIPLET_TS_EN
         chk({tag, ".ts"}, 64'(m_ts_o), 64'(q[0].ts));
`endif
      end
   endtask

   task automatic model_clear();
      q.delete();
      seq_m  = '0;
      drop_m = '0;
      ovf_m  = 1'b0;
   endtask

   // One clock: drive, advance the model to its post-edge state, then compare.
   task automatic cyc(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input logic r, input logic c);
      trip_t t;
      logic  popm;
      sample_i  = s;
      x_i       = x;
      y_i       = y;
      z_i       = z;
      m_ready_i = r;
      clear_i   = c;
      popm = r && (q.size() != 0);
      if (c) begin
         model_clear();
      end else begin
         if (s && q.size() == DEPTH && !popm) begin
            ovf_m = 1'b1;
            if (drop_m != '1) drop_m = drop_m + 1'b1;
         end
         if (popm) void'(q.pop_front());
         if (s && q.size() < DEPTH) begin
            t.x = x; t.y = y; t.z = z; t.seq = seq_m; t.ts = ts_m;
            q.push_back(t);
         end
         if (s) seq_m = seq_m + 1'b1;
      end
      @(posedge clk);
      #1;
      ts_m = ts_m + 1;
      sample_i  = 1'b0;
      m_ready_i = 1'b0;
      clear_i   = 1'b0;
      check_state(tag);
   endtask

   task automatic idle(input string tag, input logic r);
      cyc(tag, 1'b0, 32'h0, 32'h0, 32'h0, r, 1'b0);
   endtask

   task automatic samp(input string tag, input int i, input logic r);
      cyc(tag, 1'b1, 32'(i), ~32'(i), 32'(i) * 32'd3 + 32'h5a00_0000, r, 1'b0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      sample_i  = 1'b1;
      m_ready_i = 1'b1;
      x_i       = 32'hdead_beef;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      ts_m = '0;
      check_state("rst");
      chk("rst.x0", 64'(m_x_o), 64'h0);
      chk("rst.y0", 64'(m_y_o), 64'h0);
      chk("rst.z0", 64'(m_z_o), 64'h0);
      chk("rst.seq0", 64'(m_seq_o), 64'h0);
`ifdef TRIPLET_TS_EN
      chk("rst.ts0", 64'(m_ts_o), 64'h0);
`endif
      rst_n     = 1'b1;
      sample_i  = 1'b0;
      m_ready_i = 1'b0;
      x_i       = '0;
   endtask

   initial begin
      logic [31:0] ts_a;
      int lvl_max;

      // single capture
      do_reset();
      cyc("single", 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 1'b0);
      chk("single.seq0", 64'(m_seq_o), 64'h0);
      chk("single.xval", 64'(m_x_o), 64'h1111_1111);
      idle("single.pop", 1'b1);
      idle("single.after", 1'b0);

      // back-to-back with reader always ready
      do_reset();
      lvl_max = 0;
      for (int i = 0; i < 8; i++) begin
         samp("b2b", i, 1'b1);
         if (i > 0 && int'(level_o) > lvl_max) lvl_max = int'(level_o);
      end
      chk("b2b.lvlmax", 64'(lvl_max), 64'd1);
      idle("b2b.drain", 1'b1);
      idle("b2b.empty", 1'b1);

      // overflow: 20 samples, reader stalled
      do_reset();
      for (int i = 0; i < 20; i++) samp("ovf.fill", i, 1'b0);
      chk("ovf.level16", 64'(level_o), 64'd16);
      chk("ovf.drop4", 64'(drop_cnt_o), 64'd4);
      chk("ovf.flag", 64'(overflow_o), 64'd1);
      for (int i = 0; i < 16; i++) idle("ovf.drain", 1'b1);
      samp("ovf.next", 100, 1'b0);
      chk("ovf.seq20", 64'(m_seq_o), 64'd20);
      idle("ovf.pop", 1'b1);

      // full with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 16; i++) samp("fullpp.fill", i, 1'b0);
      cyc("fullpp.pp", 1'b1, 32'haaaa_aaaa, 32'hbbbb_bbbb, 32'hcccc_cccc, 1'b1, 1'b0);
      chk("fullpp.level16", 64'(level_o), 64'd16);
      chk("fullpp.nodrop", 64'(drop_cnt_o), 64'd0);
      for (int i = 0; i < 15; i++) idle("fullpp.drain", 1'b1);
      chk("fullpp.lastx", 64'(m_x_o), 64'haaaa_aaaa);
      idle("fullpp.end", 1'b1);

      // clear priority over sample and pop
      do_reset();
      for (int i = 0; i < 18; i++) samp("clr.fill", i, 1'b0);
      for (int i = 0; i < 11; i++) idle("clr.drain", 1'b1);
      chk("clr.level5", 64'(level_o), 64'd5);
      cyc("clr.go", 1'b1, 32'h7777_7777, 32'h0, 32'h0, 1'b1, 1'b1);
      chk("clr.level0", 64'(level_o), 64'd0);
      chk("clr.ovf0", 64'(overflow_o), 64'd0);
      samp("clr.next", 42, 1'b0);
      chk("clr.seq0", 64'(m_seq_o), 64'd0);
      idle("clr.pop", 1'b1);

      // mixed random traffic with occasional clears
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cyc("rand", 1'($urandom_range(0, 99) < 60), $urandom, $urandom, $urandom,
             1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
      end

      // reset mid-burst
      for (int i = 0; i < 5; i++) samp("midrst.fill", i, 1'b0);
      do_reset();
      chk("midrst.level0", 64'(level_o), 64'd0);
      samp("midrst.next", 9, 1'b0);
`ifdef TRIPLET_TS_EN
      chk("midrst.ts0", 64'(m_ts_o), 64'd0);
      idle("midrst.pop", 1'b1);
      // timestamp spacing
      samp("ts.a", 1, 1'b0);
      ts_a = m_ts_o;
      for (int i = 0; i < 9; i++) idle("ts.gap", 1'b0);
      samp("ts.b", 2, 1'b0);
      idle("ts.popa", 1'b1);
      chk("ts.delta10", 64'(m_ts_o - ts_a), 64'd10);
      idle("ts.popb", 1'b1);
`else
      ts_a = '0;
      idle("midrst.pop", 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/triplet_capture_fifo.md
# triplet_capture_fifo

Captures the three 32-bit measurement registers (x, y, z) produced by the top-level processing core as one atomic triplet on a sample strobe and buffers the triplets in a small FIFO for the processor-side readout. It sits directly downstream of the core's x/y/z outputs and upstream of the register/DMA readout, so a slow or bursty reader never sees torn triplets. Every triplet carries a sequence number, and drops on overflow are counted, so the host can detect missed samples.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in triplets; power of two, ≥ 2.
- CNT_W, 16: width of the sequence and drop counters.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset; synchronous, active-low.
- clear_i  in  1  synchronous flush and counter clear.
- sample_i  in  1  capture strobe, one-cycle pulse per sample.
- x_i  in  32  measurement word x.
- y_i  in  32  measurement word y.
- z_i  in  32  measurement word z.
- m_valid_o  out  1  head triplet available.
- m_ready_i  in  1  reader accepts the head triplet.
- m_x_o  out  32  head x.
- m_y_o  out  32  head y.
- m_z_o  out  32  head z.
- m_seq_o  out  CNT_W  sequence number of the head triplet.
- m_ts_o  out  32  capture timestamp of the head triplet; present only with TRIPLET_TS_EN.
- level_o  out  $clog2(DEPTH)+1  number of stored triplets, 0..DEPTH.
- overflow_o  out  1  sticky flag: at least one triplet was dropped.
- drop_cnt_o  out  CNT_W  number of dropped triplets; saturates at all-ones.

## Operation
- Push: sample_i=1 at a rising edge writes {x_i, y_i, z_i, seq} into the FIFO when a slot is available. The sequence counter increments on every sample_i, accepted or dropped, and wraps modulo 2^CNT_W.
- Pop: m_valid_o & m_ready_i at a rising edge removes the head. m_ready_i is ignored while m_valid_o=0.
- Slot available: level < DEPTH, or level = DEPTH with a pop in the same cycle. A simultaneous push and pop on a full FIFO is accepted, and level stays DEPTH.
- Full with no pop: the triplet is dropped. drop_cnt_o increments and saturates. overflow_o sets and stays set.
- Head outputs are registered, first-word-fall-through: while m_valid_o=1, the m_* data are stable until popped. While m_valid_o=0, m_* outputs hold their last value.
- clear_i=1 empties the FIFO and zeroes the sequence counter, drop_cnt_o and overflow_o.
  - clear_i has priority over a same-cycle sample_i and pop. The sample is discarded, is not counted as a drop, and the first sample after clear carries seq 0.
- Pointers wrap modulo DEPTH. level_o = write count − read count. Empty: level 0, m_valid_o=0. Full: level DEPTH.

## Timing
- Reset values (rst_n=0 at an edge): m_valid_o=0, m_x_o/m_y_o/m_z_o/m_seq_o/m_ts_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, sequence counter 0, timestamp counter 0.
- Reset asserted mid-operation discards all stored triplets. Inputs are ignored while rst_n=0.
- Latency: sample_i at edge N into an empty FIFO gives m_valid_o=1 with that data after edge N. There is no same-cycle bypass.
- Pop at edge N: the next triplet, if any, is presented after edge N, and m_valid_o stays 1. The last triplet popped drops m_valid_o after edge N.
- Throughput: one push and one pop per cycle, sustained.
- level_o and overflow_o update at the same edge as the push or pop that changes them.

## Configuration
- TRIPLET_TS_EN defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is stored with each triplet.
  - The counter value is taken at the sample_i edge.
  - The stored value is presented on m_ts_o.
- TRIPLET_TS_EN undefined:
  - No timestamp counter or storage exists.
  - The m_ts_o port is absent.
- All other behaviour is identical in both builds.

## Test plan
- Single capture: reset, then sample_i with x=0x11111111, y=0x22222222, z=0x33333333 -> next cycle m_valid_o=1 with the same words, m_seq_o=0, level_o=1. With m_ready_i=1, the triplet pops and m_valid_o=0 the cycle after.
- Back-to-back: 8 consecutive samples with x=i, m_ready_i=1 throughout -> triplets pop in order x=0..7 with seq=0..7. level_o never exceeds 1 after the first pop.
- Overflow, DEPTH=16: 20 samples with m_ready_i=0 -> level_o=16, drop_cnt_o=4, overflow_o=1. Draining yields seq 0..15; the next sample yields seq 20.
- Full with simultaneous push and pop: FIFO full, sample_i and m_ready_i asserted together -> no drop, level_o stays 16, and the new triplet is last out.
- Clear priority: FIFO holding 5 triplets with overflow set; clear_i, sample_i and m_ready_i asserted together -> level_o=0, drop_cnt_o=0, overflow_o=0, m_valid_o=0. The next sample carries seq 0.
- Timestamp (TRIPLET_TS_EN): samples 10 cycles apart after reset -> successive m_ts_o values differ by exactly 10. Reset mid-burst -> level_o=0 and the timestamp restarts at 0.
